// File: rtl/simmem_pkg.sv
// Shared constants and types for the simulated memory controller.
// Write-side burst length limits and the write-match FIFO entry.
package simmem_pkg;

   localparam int unsigned MaxWBurstLen   = 16;
   localparam int unsigned WBurstLenWidth = $clog2(MaxWBurstLen + 1);
   localparam int unsigned WIidWidth      = 6;

   typedef struct packed {
      logic [WIidWidth-1:0]      iid;
      logic [WBurstLenWidth-1:0] remaining;
   } wmatch_entry_t;

endpackage

// File: rtl/simmem_wmatch_fifo.sv
// Circular FIFO of write bursts awaiting data beats.
// The head entry can be rewritten in place or popped.
module simmem_wmatch_fifo
   import simmem_pkg::*;
#(
   parameter int unsigned Depth   = 8,
   parameter type         entry_t = wmatch_entry_t
) (
   input  logic   clk_i,
   input  logic   rst_ni,
   input  logic   push_i,
   input  entry_t push_entry_i,
   input  logic   upd_i,
   input  entry_t upd_entry_i,
   input  logic   pop_i,
   output entry_t head_o,
   output logic   full_o,
   output logic   empty_o
);

   localparam int unsigned AW = $clog2(Depth);

   entry_t         mem_q [Depth];
   logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
   logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
   logic [AW:0]    cnt_q, cnt_d;

   assign head_o  = mem_q[rd_ptr_q];
   assign full_o  = (cnt_q == (AW+1)'(Depth));
   assign empty_o = (cnt_q == '0);

   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      cnt_d    = cnt_q;
      if (push_i) begin
         wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (pop_i) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end
      unique case ({push_i, pop_i})
         2'b10:   cnt_d = cnt_q + (AW+1)'(1);
         2'b01:   cnt_d = cnt_q - (AW+1)'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   // Push never hits the head slot while upd is live: full blocks push, empty blocks upd.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         cnt_q    <= '0;
         for (int i = 0; i < Depth; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         cnt_q    <= cnt_d;
         if (push_i) begin
            mem_q[wr_ptr_q] <= push_entry_i;
         end
         if (upd_i) begin
            mem_q[rd_ptr_q] <= upd_entry_i;
         end
      end
   end

endmodule

// File: rtl/simmem_wdata_matcher.sv
// Pairs write-data beats with queued write bursts, emitting registered match events.
// Define SIMMEM_WDATA_MATCHER_ASSERT_EN to compile in the SVA checks.
module simmem_wdata_matcher
   import simmem_pkg::*;
#(
   parameter int unsigned IidWidth       = WIidWidth,
   parameter int unsigned MaxBurstLen    = MaxWBurstLen,
   parameter int unsigned AddrFifoDepth  = 8,
   parameter int unsigned MaxOrphanBeats = 64,
   localparam int unsigned BurstLenWidth = $clog2(MaxBurstLen + 1),
   localparam int unsigned OrphanWidth   = $clog2(MaxOrphanBeats + 1)
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     waddr_valid_i,
   output logic                     waddr_ready_o,
   input  logic [IidWidth-1:0]      waddr_iid_i,
   input  logic [BurstLenWidth-1:0] waddr_burst_len_i,
   input  logic                     wdata_valid_i,
   output logic                     wdata_ready_o,
   output logic                     match_valid_o,
   input  logic                     match_ready_i,
   output logic [IidWidth-1:0]      match_iid_o,
   output logic [BurstLenWidth-1:0] match_cnt_o,
   output logic                     match_last_o
);

   localparam int unsigned CW =
      (OrphanWidth > BurstLenWidth) ? OrphanWidth : BurstLenWidth;

   typedef struct packed {
      logic [IidWidth-1:0]      iid;
      logic [BurstLenWidth-1:0] remaining;
   } entry_t;

   entry_t head, push_entry, upd_entry;
   logic   fifo_full, fifo_empty;
   logic   push, pop, upd;

   logic [OrphanWidth-1:0]   orphan_q, orphan_d;
   logic                     valid_q, valid_d;
   logic [IidWidth-1:0]      iid_q, iid_d;
   logic [BurstLenWidth-1:0] cnt_q, cnt_d;
   logic                     last_q, last_d;

   logic          beat_acc, slot_free, do_match;
   logic [CW-1:0] avail, rem_ext, n_ext;

   assign waddr_ready_o = !fifo_full;
   assign wdata_ready_o = (orphan_q != OrphanWidth'(MaxOrphanBeats));

   assign push       = waddr_valid_i && waddr_ready_o;
   assign push_entry = '{iid: waddr_iid_i, remaining: waddr_burst_len_i};

   assign beat_acc  = wdata_valid_i && wdata_ready_o;
   assign slot_free = !valid_q || match_ready_i;
   assign avail     = CW'(orphan_q) + CW'(beat_acc);
   assign rem_ext   = CW'(head.remaining);
   assign n_ext     = (avail < rem_ext) ? avail : rem_ext;
   assign do_match  = slot_free && !fifo_empty && (avail != '0);

   assign pop       = do_match && (n_ext == rem_ext);
   assign upd       = do_match && !pop;
   assign upd_entry = '{
      iid:       head.iid,
      remaining: head.remaining - BurstLenWidth'(n_ext)
   };

   always_comb begin
      orphan_d = OrphanWidth'(avail);
      valid_d  = valid_q;
      iid_d    = iid_q;
      cnt_d    = cnt_q;
      last_d   = last_q;
      if (do_match) begin
         orphan_d = OrphanWidth'(avail - n_ext);
         valid_d  = 1'b1;
         iid_d    = head.iid;
         cnt_d    = BurstLenWidth'(n_ext);
         last_d   = (n_ext == rem_ext);
      end else if (match_ready_i) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         orphan_q <= '0;
         valid_q  <= 1'b0;
         iid_q    <= '0;
         cnt_q    <= '0;
         last_q   <= 1'b0;
      end else begin
         orphan_q <= orphan_d;
         valid_q  <= valid_d;
         iid_q    <= iid_d;
         cnt_q    <= cnt_d;
         last_q   <= last_d;
      end
   end

   assign match_valid_o = valid_q;
   assign match_iid_o   = iid_q;
   assign match_cnt_o   = cnt_q;
   assign match_last_o  = last_q;

   simmem_wmatch_fifo #(
      .Depth   (AddrFifoDepth),
      .entry_t (entry_t)
   ) u_fifo (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .push_i       (push),
      .push_entry_i (push_entry),
      .upd_i        (upd),
      .upd_entry_i  (upd_entry),
      .pop_i        (pop),
      .head_o       (head),
      .full_o       (fifo_full),
      .empty_o      (fifo_empty)
   );

`ifdef SIMMEM_WDATA_MATCHER_ASSERT_EN
   a_len_legal : assert property (@(posedge clk_i) disable iff (!rst_ni)
      push |-> (waddr_burst_len_i != '0) &&
               (waddr_burst_len_i <= BurstLenWidth'(MaxBurstLen)));

   a_out_stable : assert property (@(posedge clk_i) disable iff (!rst_ni)
      (match_valid_o && !match_ready_i) |=>
         match_valid_o && $stable(match_iid_o) &&
         $stable(match_cnt_o) && $stable(match_last_o));

   a_orphan_max : assert property (@(posedge clk_i) disable iff (!rst_ni)
      orphan_q <= OrphanWidth'(MaxOrphanBeats));

   a_no_push_full : assert property (@(posedge clk_i) disable iff (!rst_ni)
      !(push && fifo_full));

   a_cnt_nonzero : assert property (@(posedge clk_i) disable iff (!rst_ni)
      match_valid_o |-> (match_cnt_o != '0));
`endif

endmodule

// File: tb/tb_simmem_wdata_matcher.sv
// Bench for simmem_wdata_matcher: directed scenarios plus random traffic
// compared every cycle against a queue-based burst model.
module tb_simmem_wdata_matcher;

   localparam int IW     = 6;
   localparam int LW     = 5;
   localparam int MAXORP = 64;
   localparam int DEPTH  = 8;

   logic          clk_i = 1'b0;
   logic          rst_ni = 1'b0;
   logic          waddr_valid_i = 1'b0;
   logic          waddr_ready_o;
   logic [IW-1:0] waddr_iid_i = '0;
   logic [LW-1:0] waddr_burst_len_i = '0;
   logic          wdata_valid_i = 1'b0;
   logic          wdata_ready_o;
   logic          match_valid_o;
   logic          match_ready_i = 1'b0;
   logic [IW-1:0] match_iid_o;
   logic [LW-1:0] match_cnt_o;
   logic          match_last_o;

   simmem_wdata_matcher u_dut (
      .clk_i             (clk_i),
      .rst_ni            (rst_ni),
      .waddr_valid_i     (waddr_valid_i),
      .waddr_ready_o     (waddr_ready_o),
      .waddr_iid_i       (waddr_iid_i),
      .waddr_burst_len_i (waddr_burst_len_i),
      .wdata_valid_i     (wdata_valid_i),
      .wdata_ready_o     (wdata_ready_o),
      .match_valid_o     (match_valid_o),
      .match_ready_i     (match_ready_i),
      .match_iid_o       (match_iid_o),
      .match_cnt_o       (match_cnt_o),
      .match_last_o      (match_last_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      int iid;
      int rem;
   } burst_t;

   burst_t q[$];
   int     m_orph;
   bit     m_v;
   int     m_iid;
   int     m_cnt;
   bit     m_last;

   int n_chk  = 0;
   int n_fail = 0;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp,
                  $time);
      end
   endtask

   task automatic model_reset();
      q.delete();
      m_orph = 0;
      m_v    = 0;
      m_iid  = 0;
      m_cnt  = 0;
      m_last = 0;
   endtask

   // Advances the model by one clock using the inputs now applied.
   task automatic model_step(input bit av, input int aiid, input int alen,
                             input bit dv, input bit mr);
      bit     wr, ar;
      int     avail, n;
      burst_t e;
      wr    = (m_orph != MAXORP);
      ar    = (q.size() != DEPTH);
      avail = m_orph + ((dv && wr) ? 1 : 0);
      if ((!m_v || mr) && q.size() > 0 && avail > 0) begin
         e      = q[0];
         n      = (avail < e.rem) ? avail : e.rem;
         m_v    = 1;
         m_iid  = e.iid;
         m_cnt  = n;
         m_last = (n == e.rem);
         e.rem  = e.rem - n;
         if (e.rem == 0) void'(q.pop_front());
         else q[0] = e;
         m_orph = avail - n;
      end else begin
         m_orph = avail;
         if (mr) m_v = 0;
      end
      if (av && ar) q.push_back('{iid: aiid, rem: alen});
   endtask

   task automatic compare_all();
      check("valid", 32'(match_valid_o), 32'(m_v));
      check("iid", 32'(match_iid_o), m_iid);
      check("cnt", 32'(match_cnt_o), m_cnt);
      check("last", 32'(match_last_o), 32'(m_last));
      check("waddr_ready", 32'(waddr_ready_o), 32'(q.size() != DEPTH));
      check("wdata_ready", 32'(wdata_ready_o), 32'(m_orph != MAXORP));
   endtask

   // Called at a falling edge; returns at the next falling edge.
   task automatic step(input bit av, input int aiid, input int alen,
                       input bit dv, input bit mr);
      waddr_valid_i     = av;
      waddr_iid_i       = IW'(aiid);
      waddr_burst_len_i = LW'(alen);
      wdata_valid_i     = dv;
      match_ready_i     = mr;
      model_step(av, aiid, alen, dv, mr);
      @(posedge clk_i);
      @(negedge clk_i);
      compare_all();
   endtask

   task automatic do_reset();
      rst_ni        = 1'b0;
      waddr_valid_i = 1'b0;
      wdata_valid_i = 1'b0;
      match_ready_i = 1'b0;
      model_reset();
      #1;
      compare_all();
      @(posedge clk_i);
      @(negedge clk_i);
      compare_all();
      check("rst_orphan", 32'(u_dut.orphan_q), 0);
      rst_ni = 1'b1;
   endtask

   initial begin
      model_reset();
      do_reset();
      check("rst_valid", 32'(match_valid_o), 0);
      check("rst_waddr_ready", 32'(waddr_ready_o), 1);
      check("rst_wdata_ready", 32'(wdata_ready_o), 1);

      // Beats first, address later.
      for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 1);
      step(1, 3, 4, 0, 1);
      check("s1_t1_valid", 32'(match_valid_o), 0);
      step(0, 0, 0, 0, 1);
      check("s1_valid", 32'(match_valid_o), 1);
      check("s1_iid", 32'(match_iid_o), 3);
      check("s1_cnt", 32'(match_cnt_o), 4);
      check("s1_last", 32'(match_last_o), 1);
      check("s1_orphan", 32'(u_dut.orphan_q), 0);
      step(0, 0, 0, 0, 1);

      // Address first, one beat per cycle.
      step(1, 5, 3, 0, 1);
      for (int i = 0; i < 3; i++) begin
         step(0, 0, 0, 1, 1);
         check("s2_valid", 32'(match_valid_o), 1);
         check("s2_iid", 32'(match_iid_o), 5);
         check("s2_cnt", 32'(match_cnt_o), 1);
         check("s2_last", 32'(match_last_o), 32'(i == 2));
      end
      step(0, 0, 0, 0, 1);

      // Orphans spill over into the following burst.
      for (int i = 0; i < 5; i++) step(0, 0, 0, 1, 1);
      step(1, 1, 2, 0, 1);
      step(0, 0, 0, 0, 1);
      check("s3a_cnt", 32'(match_cnt_o), 2);
      check("s3a_last", 32'(match_last_o), 1);
      check("s3a_orphan", 32'(u_dut.orphan_q), 3);
      step(1, 2, 3, 0, 1);
      step(0, 0, 0, 0, 1);
      check("s3b_iid", 32'(match_iid_o), 2);
      check("s3b_cnt", 32'(match_cnt_o), 3);
      check("s3b_last", 32'(match_last_o), 1);
      step(0, 0, 0, 0, 1);

      // Backpressure while beats accumulate.
      step(1, 7, 8, 0, 1);
      step(0, 0, 0, 1, 0);
      for (int i = 0; i < 4; i++) begin
         step(0, 0, 0, 1, 0);
         check("s4_hold_valid", 32'(match_valid_o), 1);
         check("s4_hold_iid", 32'(match_iid_o), 7);
         check("s4_hold_cnt", 32'(match_cnt_o), 1);
         check("s4_hold_last", 32'(match_last_o), 0);
      end
      step(0, 0, 0, 0, 1);
      check("s4_rel_cnt", 32'(match_cnt_o), 4);
      check("s4_rel_last", 32'(match_last_o), 0);
      for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 1);
      check("s4_end_last", 32'(match_last_o), 1);
      step(0, 0, 0, 0, 1);

      // Orphan store fills up.
      for (int i = 0; i < 64; i++) step(0, 0, 0, 1, 1);
      check("s5_wdata_ready", 32'(wdata_ready_o), 0);
      step(0, 0, 0, 1, 1);
      check("s5_orphan", 32'(u_dut.orphan_q), 64);
      do_reset();

      // Address queue fills up, one pop frees it.
      for (int i = 0; i < 8; i++) step(1, i, 1, 0, 1);
      check("s6_full", 32'(waddr_ready_o), 0);
      step(0, 0, 0, 1, 1);
      check("s6_refree", 32'(waddr_ready_o), 1);
      check("s6_iid", 32'(match_iid_o), 0);
      do_reset();

      // Reset with orphans and a queued address outstanding.
      for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 1);
      step(1, 4, 16, 0, 0);
      check("s7_pre_orphan", 32'(u_dut.orphan_q), 3);
      do_reset();
      step(1, 9, 2, 0, 1);
      step(0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 1);
      check("s7_no_event", 32'(match_valid_o), 0);
      step(0, 0, 0, 1, 1);
      check("s7_valid", 32'(match_valid_o), 1);
      check("s7_iid", 32'(match_iid_o), 9);
      check("s7_cnt", 32'(match_cnt_o), 1);
      step(0, 0, 0, 1, 1);
      check("s7_last", 32'(match_last_o), 1);

      // Random traffic in phases of varying pressure.
      for (int ph = 0; ph < 6; ph++) begin
         int pa, pd, pr;
         pa = (ph % 3 == 0) ? 1 : 3;
         pd = (ph % 2 == 0) ? 1 : 3;
         pr = (ph > 3) ? 1 : 3;
         for (int c = 0; c < 600; c++) begin
            step($urandom_range(0, pa) == 0, int'($urandom_range(0, 63)),
                 int'($urandom_range(1, 16)), $urandom_range(0, pd) != 0,
                 $urandom_range(0, pr) != 0);
         end
      end
      do_reset();

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
